// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: front-end PC holder and fetch-address generator.
// Issues req/gnt/rvalid fetches with up to MAX_OUTSTANDING in flight, tracks
// each in-flight address in a small FIFO, squashes stale responses after a
// jump and hands registered instruction/address pairs to decode.
// Optional build macro PC_MISALIGN_CHK_EN: adds jump_misalign_o and forces
// jump targets to word alignment.
module pc_fetch_gen #(
   parameter int unsigned       ADDR_W          = 32,
   parameter int unsigned       DATA_W          = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR      = '0,
   parameter int unsigned       STEP            = 4,
   parameter int unsigned       MAX_OUTSTANDING = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              jtag_reset_flag_i,
   input  logic              stall_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              inst_valid_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              busy_o
`ifdef PC_MISALIGN_CHK_EN
   ,
   output logic              jump_misalign_o
`endif
);

   localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

   logic [ADDR_W-1:0]                       pc_q, pc_d;
   logic [MAX_OUTSTANDING-1:0][ADDR_W-1:0]  fifo_addr_q, fifo_addr_d;
   logic [MAX_OUTSTANDING-1:0]              stale_q, stale_d;
   logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                        cnt_q, cnt_d;
   logic                                    inst_valid_q, inst_valid_d;
   logic [DATA_W-1:0]                       inst_q, inst_d;
   logic [ADDR_W-1:0]                       inst_addr_q, inst_addr_d;
   logic [ADDR_W-1:0]                       jump_tgt;
   logic                                    push, pop;
`ifdef PC_MISALIGN_CHK_EN
   logic                                    misalign_q, misalign_d;
`endif

   // Pointers wrap at the FIFO depth, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Request gating, FIFO bookkeeping and next-state selection.
   always_comb begin
      // rst_ni is folded in so req_o stays low while the async reset is held.
      req_o = rst_ni && !jtag_reset_flag_i && !stall_i && !jump_flag_i && (cnt_q < CNT_MAX);
      push  = req_o && gnt_i;
      // An rvalid with nothing outstanding is a protocol error and is ignored.
      pop   = rvalid_i && (cnt_q != '0);

`ifdef PC_MISALIGN_CHK_EN
      jump_tgt   = {jump_addr_i[ADDR_W-1:2], 2'b00};
      misalign_d = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
`else
      jump_tgt   = jump_addr_i;
`endif

      pc_d         = pc_q;
      fifo_addr_d  = fifo_addr_q;
      stale_d      = stale_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;

      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         if (!stale_q[rd_ptr_q] && !jump_flag_i) begin
            inst_valid_d = 1'b1;
            inst_d       = rdata_i;
            inst_addr_d  = fifo_addr_q[rd_ptr_q];
         end
      end

      // Marking every slot is safe: empty slots get stale=0 again when pushed.
      if (jump_flag_i) begin
         pc_d    = jump_tgt;
         stale_d = '1;
      end else if (push) begin
         pc_d                  = pc_q + ADDR_W'(STEP);
         fifo_addr_d[wr_ptr_q] = pc_q;
         stale_d[wr_ptr_q]     = 1'b0;
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // Debug reset overrides everything else at the next edge.
      if (jtag_reset_flag_i) begin
         pc_d         = RESET_ADDR;
         stale_d      = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         cnt_d        = '0;
         inst_valid_d = 1'b0;
         inst_d       = '0;
         inst_addr_d  = '0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_d   = 1'b0;
`endif
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q         <= RESET_ADDR;
         fifo_addr_q  <= '0;
         stale_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_addr_q  <= '0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         pc_q         <= pc_d;
         fifo_addr_q  <= fifo_addr_d;
         stale_q      <= stale_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
`ifdef PC_MISALIGN_CHK_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   assign addr_o       = pc_q;
   assign pc_o         = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;
   assign busy_o       = (cnt_q != '0);
`ifdef PC_MISALIGN_CHK_EN
   assign jump_misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Testbench for pc_fetch_gen: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the fetch front end.
module tb_pc_fetch_gen;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        jtag = 1'b0, stall = 1'b0, jump = 1'b0, gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] jaddr = '0, rdata = '0;
   logic        req_o, inst_valid_o, busy_o;
   logic [31:0] addr_o, pc_o, inst_o, inst_addr_o;
`ifdef PC_MISALIGN_CHK_EN
   logic        jump_misalign_o;
`endif

   int n_chk = 0, n_pass = 0;

   pc_fetch_gen #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .jtag_reset_flag_i(jtag), .stall_i(stall),
      .jump_flag_i(jump), .jump_addr_i(jaddr), .req_o(req_o), .addr_o(addr_o),
      .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .pc_o(pc_o),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .busy_o(busy_o)
`ifdef PC_MISALIGN_CHK_EN
      , .jump_misalign_o(jump_misalign_o)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] a; bit s; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc, m_inst, m_ia;
   bit          m_v, m_mis;

   function automatic void m_reset();
      m_q.delete(); m_pc = 32'h0; m_v = 0; m_inst = 0; m_ia = 0; m_mis = 0;
   endfunction

   function automatic bit m_req();
      return rst_ni && !jtag && !stall && !jump && (m_q.size() < MAXO);
   endfunction

   // Advance model by one clock using the current inputs, then step the DUT.
   task automatic tick();
      bit   r  = m_req();
      bit   nv = 0;
      ent_t h;
      if (!rst_ni || jtag) m_reset();
      else begin
         if (rvalid && m_q.size() > 0) begin
            h = m_q.pop_front();
            if (!h.s && !jump) begin nv = 1; m_inst = rdata; m_ia = h.a; end
         end
         m_mis = 0;
         if (jump) begin
            foreach (m_q[i]) m_q[i].s = 1;
`ifdef PC_MISALIGN_CHK_EN
            m_pc  = jaddr & 32'hFFFF_FFFC;
            m_mis = (jaddr % 4) != 0;
`else
            m_pc  = jaddr;
`endif
         end else if (r && gnt) begin
            m_q.push_back('{a: m_pc, s: 0});
            m_pc = m_pc + 32'd4;
         end
         m_v = nv;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      jtag = 0; stall = 0; jump = 0; gnt = 0; rvalid = 0; jaddr = 0; rdata = 0;
   endtask

   task automatic clean();
      idle_inputs(); jtag = 1; tick(); jtag = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs(); rst_ni = 0; m_reset(); #1;
      n_chk++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else n_pass++;
      n_chk++; if (req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", req_o); else n_pass++;
      n_chk++; if (busy_o !== 1'b0 || inst_valid_o !== 1'b0) $display("FAIL reset_flags: busy %b valid %b want 0 0", busy_o, inst_valid_o); else n_pass++;
      n_chk++; if (inst_o !== 32'h0 || inst_addr_o !== 32'h0) $display("FAIL reset_inst: inst %h addr %h want 0 0", inst_o, inst_addr_o); else n_pass++;
      @(posedge clk); #1; rst_ni = 1;
   endtask

   task automatic test_free_run();
      bit prev_g = 0;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         gnt = 1; rvalid = prev_g; d = $urandom; rdata = d; #1;
         n_chk++; if (addr_o !== 32'(4*i)) $display("FAIL free_addr%0d: got %h want %h", i, addr_o, 32'(4*i)); else n_pass++;
         prev_g = m_req();
         tick();
         if (i > 0) begin
            n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4*(i-1)) || inst_o !== d)
               $display("FAIL free_deliver%0d: v %b addr %h inst %h want 1 %h %h", i, inst_valid_o, inst_addr_o, inst_o, 32'(4*(i-1)), d);
            else n_pass++;
         end
      end
      idle_inputs();
   endtask

   task automatic test_outstanding_limit();
      clean(); gnt = 1;
      tick(); tick(); #1;
      n_chk++; if (req_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL limit_full: req %b busy %b want 0 1", req_o, busy_o); else n_pass++;
      rvalid = 1; rdata = 32'hA5A5_0001; #1;
      n_chk++; if (req_o !== 1'b0) $display("FAIL limit_same_cycle_pop: req %b want 0", req_o); else n_pass++;
      tick(); rvalid = 0; #1;
      n_chk++; if (req_o !== 1'b1) $display("FAIL limit_reopen: req %b want 1", req_o); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_jump();
      clean(); gnt = 1; tick(); tick();
      gnt = 0; jump = 1; jaddr = 32'h100; tick(); jump = 0;
      n_chk++; if (pc_o !== 32'h100 || inst_valid_o !== 1'b0) $display("FAIL jump_pc: pc %h v %b want 100 0", pc_o, inst_valid_o); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         rvalid = 1; rdata = $urandom; tick();
         n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL jump_drop%0d: v %b want 0", i, inst_valid_o); else n_pass++;
      end
      rvalid = 0; gnt = 1; #1;
      n_chk++; if (addr_o !== 32'h100 || req_o !== 1'b1) $display("FAIL jump_refetch: addr %h req %b want 100 1", addr_o, req_o); else n_pass++;
      tick(); gnt = 0; rvalid = 1; rdata = 32'hCAFE_0100; tick(); rvalid = 0;
      n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== 32'hCAFE_0100)
         $display("FAIL jump_target_deliver: v %b addr %h inst %h want 1 100 cafe0100", inst_valid_o, inst_addr_o, inst_o);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_jump_rvalid();
      clean(); gnt = 1; tick(); gnt = 0;
      rvalid = 1; rdata = 32'h1234_5678; jump = 1; jaddr = 32'h200; tick(); idle_inputs();
      n_chk++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h200 || busy_o !== 1'b0)
         $display("FAIL jump_rvalid: v %b pc %h busy %b want 0 200 0", inst_valid_o, pc_o, busy_o);
      else n_pass++;
   endtask

   task automatic test_stall_wrap();
      clean(); jump = 1; jaddr = 32'hFFFF_FFF8; tick(); jump = 0;
      gnt = 1; tick();
      n_chk++; if (pc_o !== 32'hFFFF_FFFC || busy_o !== 1'b1) $display("FAIL wrap_setup: pc %h busy %b want fffffffc 1", pc_o, busy_o); else n_pass++;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rvalid = (i == 0); rdata = 32'hBEEF_0000 + 32'(i); #1;
         n_chk++; if (req_o !== 1'b0) $display("FAIL stall_req%0d: req %b want 0", i, req_o); else n_pass++;
         tick();
         if (i == 0) begin
            n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFF8 || inst_o !== 32'hBEEF_0000)
               $display("FAIL stall_deliver: v %b addr %h inst %h want 1 fffffff8 beef0000", inst_valid_o, inst_addr_o, inst_o);
            else n_pass++;
         end
      end
      stall = 0; rvalid = 0; tick();
      n_chk++; if (pc_o !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc_o); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_jtag_reset();
      clean(); jump = 1; jaddr = 32'h40; tick(); jump = 0;
      gnt = 1; tick(); tick(); gnt = 0;
      jtag = 1; gnt = 1; jump = 1; jaddr = 32'h80; tick(); idle_inputs();
      n_chk++; if (pc_o !== 32'h0 || busy_o !== 1'b0) $display("FAIL jtag_reset: pc %h busy %b want 0 0", pc_o, busy_o); else n_pass++;
      rvalid = 1; rdata = 32'h5555_AAAA; tick(); rvalid = 0;
      n_chk++; if (inst_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL jtag_ignore_rvalid: v %b busy %b want 0 0", inst_valid_o, busy_o); else n_pass++;
   endtask

   task automatic test_async_reset();
      clean(); gnt = 1; tick(); gnt = 0; rvalid = 1; rdata = 32'h7777_1111; tick(); rvalid = 0;
      gnt = 1; tick(); gnt = 0;
      n_chk++; if (inst_o !== 32'h7777_1111 || busy_o !== 1'b1) $display("FAIL async_pre: inst %h busy %b want 77771111 1", inst_o, busy_o); else n_pass++;
      #2 rst_ni = 0; #1;
      n_chk++; if (pc_o !== 32'h0 || busy_o !== 1'b0 || req_o !== 1'b0) $display("FAIL async_state: pc %h busy %b req %b want 0 0 0", pc_o, busy_o, req_o); else n_pass++;
      n_chk++; if (inst_o !== 32'h0 || inst_addr_o !== 32'h0 || inst_valid_o !== 1'b0) $display("FAIL async_out: inst %h addr %h v %b want 0 0 0", inst_o, inst_addr_o, inst_valid_o); else n_pass++;
      #1 rst_ni = 1; m_reset();
      @(posedge clk); #1;
   endtask

`ifdef PC_MISALIGN_CHK_EN
   task automatic test_misalign();
      clean(); jump = 1; jaddr = 32'h102; tick(); jump = 0;
      n_chk++; if (pc_o !== 32'h100 || jump_misalign_o !== 1'b1) $display("FAIL misalign_jump: pc %h mis %b want 100 1", pc_o, jump_misalign_o); else n_pass++;
      tick();
      n_chk++; if (jump_misalign_o !== 1'b0) $display("FAIL misalign_pulse: mis %b want 0", jump_misalign_o); else n_pass++;
   endtask
`endif

   task automatic test_random();
      clean();
      for (int c = 0; c < 500; c++) begin
         jtag   = ($urandom_range(0, 59) == 0);
         stall  = ($urandom_range(0, 3) == 0);
         jump   = ($urandom_range(0, 11) == 0);
         jaddr  = $urandom;
         gnt    = $urandom_range(0, 1);
         rvalid = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
         rdata  = $urandom;
         #1;
         n_chk++; if (req_o !== m_req() || addr_o !== m_pc) $display("FAIL rnd_req c%0d: req %b addr %h want %b %h", c, req_o, addr_o, m_req(), m_pc); else n_pass++;
         tick();
         n_chk++; if (pc_o !== m_pc || busy_o !== (m_q.size() != 0)) $display("FAIL rnd_state c%0d: pc %h busy %b want %h %b", c, pc_o, busy_o, m_pc, m_q.size() != 0); else n_pass++;
         n_chk++; if (inst_valid_o !== m_v || inst_o !== m_inst || inst_addr_o !== m_ia)
            $display("FAIL rnd_inst c%0d: v %b inst %h addr %h want %b %h %h", c, inst_valid_o, inst_o, inst_addr_o, m_v, m_inst, m_ia);
         else n_pass++;
`ifdef PC_MISALIGN_CHK_EN
         n_chk++; if (jump_misalign_o !== m_mis) $display("FAIL rnd_mis c%0d: got %b want %b", c, jump_misalign_o, m_mis); else n_pass++;
`endif
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_outstanding_limit();
      test_jump();
      test_jump_rvalid();
      test_stall_wrap();
      test_jtag_reset();
      test_async_reset();
`ifdef PC_MISALIGN_CHK_EN
      test_misalign();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
Parametrised next-generation PC and fetch-address generator for the core front end. It holds the PC and issues fetch requests on a req/gnt/rvalid instruction bus with up to MAX_OUTSTANDING requests in flight. It tracks the address of each outstanding request in an internal FIFO. On a jump it redirects the PC and marks in-flight responses stale so they are silently dropped. It delivers registered instruction/address pairs to decode.

Parameters:
ADDR_W, 32, width of PC, jump address and bus address.
DATA_W, 32, width of instruction data.
RESET_ADDR, 32'h0000_0000, PC value after reset or JTAG reset.
STEP, 4, PC increment per granted request, in bytes.
MAX_OUTSTANDING, 2, depth of outstanding-request FIFO; allowed range 1..8.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
jtag_reset_flag_i  input  1  synchronous reset request from debug module
stall_i  input  1  hold: suppress new requests
jump_flag_i  input  1  redirect PC this cycle
jump_addr_i  input  ADDR_W  redirect target
req_o  output  1  fetch request
addr_o  output  ADDR_W  fetch address (equals pc_o)
gnt_i  input  1  request accepted this cycle
rvalid_i  input  1  response data valid, in request order
rdata_i  input  DATA_W  response instruction
pc_o  output  ADDR_W  current fetch PC
inst_valid_o  output  1  registered instruction valid (one-cycle pulse per instruction)
inst_o  output  DATA_W  registered instruction
inst_addr_o  output  ADDR_W  address of inst_o
busy_o  output  1  FIFO non-empty (requests outstanding)

Behaviour:
- Reset is asynchronous, active-low: rst_ni=0 forces pc_o=RESET_ADDR, FIFO empty (count=0, all stale bits 0), inst_valid_o=0, inst_o=0, inst_addr_o=0.
- jtag_reset_flag_i=1: same state at the next clock edge, applied synchronously; it has priority over every other input.
- req_o = !stall_i && !jump_flag_i && (count < MAX_OUTSTANDING). The count is the registered value; a same-cycle pop does not free a slot. req_o is low during both resets.
- Grant (req_o && gnt_i): push {pc_o, stale=0} into the FIFO; pc_o <= pc_o + STEP, with modulo 2^ADDR_W wrap-around.
- Jump: pc_o <= jump_addr_i. Every entry present in the FIFO at that edge has its stale bit set, including the entry at the head. No push occurs, because req_o is masked. A jump has priority over increment. inst_valid_o is 0 in the cycle after the jump.
- Response (rvalid_i=1): pop the FIFO head. If the head is not stale and jump_flag_i=0, then on the next cycle inst_valid_o=1, inst_o=rdata_i and inst_addr_o=head address. Otherwise drop the response, and inst_valid_o=0 next cycle.
- Simultaneous push and pop: count is unchanged and the FIFO pointers both advance. Pointers wrap modulo MAX_OUTSTANDING.
- rvalid_i with an empty FIFO is a bus protocol error: ignore it, with no pop and no output.
- Latency: rvalid_i at edge N gives inst_valid_o high after edge N+1 (1 cycle).
- inst_o and inst_addr_o hold their last value while inst_valid_o=0.
- stall_i blocks only new requests. Outstanding responses are still accepted and delivered.
- busy_o = (count != 0).

Optional Feature:
Macro PC_MISALIGN_CHK_EN.
- Defined: adds output port jump_misalign_o, 1 bit, registered, reset 0. When jump_flag_i=1 and jump_addr_i[1:0] != 0:
  - jump_misalign_o=1 for one cycle;
  - the PC is still loaded with jump_addr_i & ~3;
  - FIFO entries are still marked stale.
- Not defined: port absent; jump_addr_i is loaded unmodified.

Test Plan:
1. Reset/free-run: release rst_ni with gnt_i=1 and a 1-cycle rvalid_i echo. Required: addr_o sequence 0x0, 0x4, 0x8. Each inst_addr_o matches its address, delivered 1 cycle after the corresponding rvalid_i.
2. Outstanding limit: MAX_OUTSTANDING=2, gnt_i=1, rvalid_i held 0. Required: after two grants req_o=0 and busy_o=1. The first rvalid_i does not re-raise req_o until the next cycle.
3. Jump with two in flight: grants at 0x0 and 0x4, then jump_flag_i=1 with 0x100. Required: both later responses are dropped (inst_valid_o stays 0), the next addr_o=0x100, and its response is delivered with inst_addr_o=0x100.
4. Jump coincident with rvalid_i: the popped head is dropped, inst_valid_o=0 next cycle, and pc_o=jump target.
5. Stall and wrap: pc_o=0xFFFF_FFFC, stall_i=1 for 3 cycles with one outstanding. Required: the response is still delivered. After stall release and grant, pc_o=0x0000_0000.
6. Reset mid-operation: assert jtag_reset_flag_i with two outstanding. Required: next cycle pc_o=RESET_ADDR and busy_o=0; later rvalid_i is ignored. Then an asynchronous rst_ni pulse mid-cycle clears outputs immediately. With PC_MISALIGN_CHK_EN: a jump to 0x102 yields pc_o=0x100 and a one-cycle jump_misalign_o pulse.
